// File: rtl/magic_square_gen.sv
// magic_square_gen: emits the Lo Shu square and its seven rotations and
// reflections as 3x3 BCD digits on a valid/ready handshake. Optional
// error mode overwrites num9 with num1 so each square has a repeated digit.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   start, err_mode         : begin a run (IDLE only); corruption latched at start
//   ready                   : consumer accepts the presented square
//   valid, num1..num9       : square presented, row-major digits
//   index, last             : variant number, final square of the run
//   done                    : one-cycle pulse after the final transfer
//   magic_constant          : constant BCD 15
module magic_square_gen #(
   parameter int NUM_SQUARES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       err_mode,
   input  logic       ready,
   output logic       valid,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic [3:0] num4,
   output logic [3:0] num5,
   output logic [3:0] num6,
   output logic [3:0] num7,
   output logic [3:0] num8,
   output logic [3:0] num9,
   output logic [2:0] index,
   output logic       last,
   output logic       done,
   output logic [7:0] magic_constant
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_SQUARES - 1);

   // Base square, num1 in the low nibble: 2 7 6 / 9 5 1 / 4 3 8
   localparam logic [35:0] BASE = {
      4'd8, 4'd3, 4'd4,
      4'd1, 4'd5, 4'd9,
      4'd6, 4'd7, 4'd2
   };

   state_t      state_q, state_d;
   logic [2:0]  index_q, index_d;
   logic        err_q, err_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic [35:0] sq_q, sq_d;

   // One clockwise quarter-turn: new[r][c] = old[2-c][r]
   function automatic logic [35:0] rot_cw(input logic [35:0] s);
      logic [35:0] o;
      o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            o[4*(3*r+c) +: 4] = s[4*(3*(2-c)+r) +: 4];
         end
      end
      return o;
   endfunction

   // Horizontal mirror: new[r][c] = old[r][2-c]
   function automatic logic [35:0] mirror(input logic [35:0] s);
      logic [35:0] o;
      o = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            o[4*(3*r+c) +: 4] = s[4*(3*r+2-c) +: 4];
         end
      end
      return o;
   endfunction

   function automatic logic [35:0] variant(
      input logic [2:0] k,
      input logic       corrupt
   );
      logic [35:0] s;
      s = BASE;
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < k[1:0]) begin
            s = rot_cw(s);
         end
      end
      if (k[2]) begin
         s = mirror(s);
      end
      // Duplicate num1 into num9 so the square is no longer unique
      if (corrupt) begin
         s[35:32] = s[3:0];
      end
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               index_d = 3'd0;
               err_d   = err_mode;
               state_d = SEND;
            end
         end
         SEND: begin
            if (ready) begin
               if (index_q == LAST_IDX) begin
                  index_d = 3'd0;
                  state_d = DONE;
               end else begin
                  index_d = index_q + 3'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            index_d = 3'd0;
         end
      endcase
      // Outputs are computed from next state so they leave flops directly
      valid_d = (state_d == SEND);
      done_d  = (state_d == DONE);
      last_d  = valid_d && (index_d == LAST_IDX);
      sq_d    = valid_d ? variant(index_d, err_d) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         index_q <= 3'd0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         sq_q    <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         sq_q    <= sq_d;
      end
   end

   assign valid = valid_q;
   assign index = index_q;
   assign last  = last_q;
   assign done  = done_q;
   assign num1  = sq_q[3:0];
   assign num2  = sq_q[7:4];
   assign num3  = sq_q[11:8];
   assign num4  = sq_q[15:12];
   assign num5  = sq_q[19:16];
   assign num6  = sq_q[23:20];
   assign num7  = sq_q[27:24];
   assign num8  = sq_q[31:28];
   assign num9  = sq_q[35:32];
   assign magic_constant = 8'h15;

endmodule

// File: tb/tb_magic_square_gen.sv
// tb_magic_square_gen: randomized bench for magic_square_gen
// against a table-plus-mirror model of the square sequence.
module tb_magic_square_gen;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        err_mode = 1'b0;
   logic        ready = 1'b0;
   logic        valid;
   logic        last;
   logic        done;
   logic [2:0]  index;
   logic [7:0]  mc;
   logic [35:0] sq;

   logic        sm_start [2];
   logic        sm_ready [2];
   logic        sm_valid [2];
   logic        sm_last [2];
   logic        sm_done [2];
   logic [2:0]  sm_index [2];
   logic [7:0]  sm_mc [2];
   logic [35:0] sm_sq [2];

   int n_tests = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   magic_square_gen #(.NUM_SQUARES(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .err_mode(err_mode), .ready(ready), .valid(valid),
      .num1(sq[3:0]), .num2(sq[7:4]), .num3(sq[11:8]),
      .num4(sq[15:12]), .num5(sq[19:16]), .num6(sq[23:20]),
      .num7(sq[27:24]), .num8(sq[31:28]), .num9(sq[35:32]),
      .index(index), .last(last), .done(done),
      .magic_constant(mc)
   );

   for (genvar g = 0; g < 2; g++) begin : g_small
      magic_square_gen #(.NUM_SQUARES(g == 0 ? 1 : 3)) dut_s (
         .clock(clock), .reset(reset), .start(sm_start[g]),
         .err_mode(1'b0), .ready(sm_ready[g]),
         .valid(sm_valid[g]),
         .num1(sm_sq[g][3:0]), .num2(sm_sq[g][7:4]),
         .num3(sm_sq[g][11:8]), .num4(sm_sq[g][15:12]),
         .num5(sm_sq[g][19:16]), .num6(sm_sq[g][23:20]),
         .num7(sm_sq[g][27:24]), .num8(sm_sq[g][31:28]),
         .num9(sm_sq[g][35:32]),
         .index(sm_index[g]), .last(sm_last[g]),
         .done(sm_done[g]), .magic_constant(sm_mc[g])
      );
   end

   // Base square and its three rotations, straight from the listing
   localparam int T [4][9] = '{
      '{2, 7, 6, 9, 5, 1, 4, 3, 8},
      '{4, 9, 2, 3, 5, 7, 8, 1, 6},
      '{8, 3, 4, 1, 5, 9, 6, 7, 2},
      '{6, 1, 8, 7, 5, 3, 2, 9, 4}
   };

   function automatic logic [35:0] model_sq(input int k, input bit err);
      int s [9];
      int m [9];
      logic [35:0] o;
      for (int i = 0; i < 9; i++) s[i] = T[k % 4][i];
      if (k >= 4) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               m[r*3+c] = s[r*3+2-c];
         for (int i = 0; i < 9; i++) s[i] = m[i];
      end
      if (err) s[8] = s[0];
      o = '0;
      for (int i = 0; i < 9; i++) o[4*i +: 4] = 4'(s[i]);
      return o;
   endfunction

   function automatic bit is_magic(input logic [35:0] q);
      int d [9];
      bit ok;
      for (int i = 0; i < 9; i++) d[i] = int'(q[4*i +: 4]);
      ok = 1;
      for (int r = 0; r < 3; r++)
         if (d[3*r] + d[3*r+1] + d[3*r+2] != 15) ok = 0;
      for (int c = 0; c < 3; c++)
         if (d[c] + d[c+3] + d[c+6] != 15) ok = 0;
      if (d[0] + d[4] + d[8] != 15) ok = 0;
      if (d[2] + d[4] + d[6] != 15) ok = 0;
      return ok;
   endfunction

   function automatic bit is_unique(input logic [35:0] q);
      logic [15:0] mask;
      mask = '0;
      for (int i = 0; i < 9; i++) mask[q[4*i +: 4]] = 1'b1;
      return mask == 16'h03FE;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      for (int g = 0; g < 2; g++) begin
         sm_start[g] = 1'b0;
         sm_ready[g] = 1'b0;
      end
      @(negedge clock);
      n_tests++;
      if (mc !== 8'h15) begin
         n_fail++;
         $display("FAIL rst_mc got %h want 15", mc);
      end
      @(negedge clock);
      n_tests++;
      if ({valid, done, last, index, sq} !== '0) begin
         n_fail++;
         $display("FAIL rst_outs v%b d%b l%b i%0d sq %h want 0",
                  valid, done, last, index, sq);
      end
      reset = 1'b0;
      @(negedge clock);
      n_tests++;
      if (valid !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold v%b d%b want 0", valid, done);
      end
   endtask

   // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready
   task automatic run8(input bit err, input int mode,
                       input bit disturb, input string name);
      int exp, done_cnt, cyc, hold1;
      bit fin, r;
      exp = 0;
      done_cnt = 0;
      hold1 = 0;
      cyc = 0;
      fin = 0;
      @(negedge clock);
      start = 1'b1;
      err_mode = err;
      ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      n_tests++;
      if (valid !== 1'b1 || index !== 3'd0) begin
         n_fail++;
         $display("FAIL %s start_lat v%b i%0d want v1 i0",
                  name, valid, index);
      end
      while (!fin && cyc < 200) begin
         if (valid === 1'b1) begin
            n_tests++;
            if (index !== 3'(exp) || done !== 1'b0 ||
                last !== (exp == 7) ||
                sq !== model_sq(exp, err)) begin
               n_fail++;
               $display("FAIL %s sq i%0d l%b d%b %h want i%0d %h",
                        name, index, last, done, sq,
                        exp, model_sq(exp, err));
            end
            n_tests++;
            if (err ? is_unique(sq)
                    : !(is_magic(sq) && is_unique(sq))) begin
               n_fail++;
               $display("FAIL %s check i%0d m%b u%b err%b",
                        name, index, is_magic(sq),
                        is_unique(sq), err);
            end
            if (index === 3'd1) hold1++;
            case (mode)
               0: r = 1'b1;
               1: r = (cyc % 3 == 0);
               default: r = 1'($urandom_range(0, 1));
            endcase
            ready = r;
            if (disturb) begin
               start = 1'($urandom_range(0, 1));
               err_mode = 1'($urandom_range(0, 1));
            end
            if (r) exp++;
         end else begin
            start = 1'b0;
            ready = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin
               done_cnt++;
               n_tests++;
               if (exp != 8) begin
                  n_fail++;
                  $display("FAIL %s early_done xfers %0d want 8",
                           name, exp);
               end
            end else begin
               if (done_cnt == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL %s valid_drop xfers %0d want 8",
                           name, exp);
               end
               fin = 1;
            end
         end
         cyc++;
         if (!fin) @(negedge clock);
      end
      n_tests++;
      if (!fin || exp != 8 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL %s run xfers %0d dones %0d fin %0b want 8 1 1",
                  name, exp, done_cnt, fin);
      end
      if (mode == 1) begin
         n_tests++;
         if (hold1 != 3) begin
            n_fail++;
            $display("FAIL %s hold_idx1 got %0d want 3", name, hold1);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen, bad;
      seen = 0;
      bad = 0;
      @(negedge clock);
      start = 1'b1;
      err_mode = 1'($urandom_range(0, 1));
      ready = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (valid === 1'b1 && index === 3'd3) seen = 1;
         else @(negedge clock);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL mid_rst timeout idx3 not seen");
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_tests++;
      if ({valid, done, last, index, sq} !== '0 || mc !== 8'h15) begin
         n_fail++;
         $display("FAIL mid_rst v%b d%b l%b i%0d sq %h mc %h want 0",
                  valid, done, last, index, sq, mc);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (done !== 1'b0 || valid !== 1'b0) bad = 1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL mid_rst_quiet got activity want idle");
      end
   endtask

   task automatic test_small(input int g, input int n);
      int exp, done_cnt;
      @(negedge clock);
      sm_start[g] = 1'b1;
      sm_ready[g] = 1'b1;
      @(negedge clock);
      sm_start[g] = 1'b0;
      exp = 0;
      done_cnt = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (sm_valid[g] === 1'b1) begin
            n_tests++;
            if (sm_index[g] !== 3'(exp) ||
                sm_last[g] !== (exp == n - 1) ||
                sm_sq[g] !== model_sq(exp, 1'b0)) begin
               n_fail++;
               $display("FAIL n%0d sq i%0d l%b %h want i%0d %h",
                        n, sm_index[g], sm_last[g], sm_sq[g],
                        exp, model_sq(exp, 1'b0));
            end
            exp++;
         end else if (sm_done[g] === 1'b1) begin
            done_cnt++;
         end
         @(negedge clock);
      end
      n_tests++;
      if (exp != n || done_cnt != 1) begin
         n_fail++;
         $display("FAIL n%0d run xfers %0d dones %0d want %0d 1",
                  n, exp, done_cnt, n);
      end
   endtask

   initial begin
      test_reset();
      run8(1'b0, 0, 1'b0, "normal");
      run8(1'b1, 0, 1'b0, "err");
      run8(1'b0, 1, 1'b0, "backpressure");
      run8(1'b1, 2, 1'b1, "disturb_err");
      run8(1'b0, 2, 1'b1, "disturb_ok");
      run8(1'($urandom_range(0, 1)), 2, 1'b0, "replay");
      test_reset_mid();
      run8(1'b0, 0, 1'b0, "after_reset");
      test_small(0, 1);
      test_small(1, 3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/magic_square_gen.md
# magic_square_gen

Stimulus-side companion to the 3x3 magic-square checker (`isUnique`, `sumt`). It emits a sequence of 3x3 squares of BCD digits on the same nine 4-bit operand lanes the checker consumes, using a valid/ready handshake. The sequence is the Lo Shu square and its rotations and reflections. An error mode corrupts every emitted square so the checker's rejection path is exercised. It sits between the test controller and the checker datapath, with the checker as the consumer.

## Interface
- `NUM_SQUARES`, default 8: number of squares emitted per run, legal range 1..8.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `err_mode` in 1: latched on an accepted start; 1 corrupts every square in the run.
- `ready` in 1: consumer accepts the current square.
- `valid` out 1: a square is presented on num1..num9.
- `num1`..`num9` out 4 each: square digits, row-major (num1..num3 top row).
- `index` out 3: variant number of the presented square, 0..7.
- `last` out 1: presented square is the final one of the run; qualified by valid.
- `done` out 1: one-cycle pulse after the final handshake.
- `magic_constant` out 8: constant 8'h15 (BCD 15), the expected line sum.

## Operation
- Base square B (variant 0), row-major: 2 7 6 / 9 5 1 / 4 3 8.
- Variant k encoding:
  - k[1:0] = number of clockwise quarter-turns applied to B. One turn maps new[r][c] = old[2-c][r].
  - k[2] = 1 applies a horizontal mirror after the rotation, new[r][c] = old[r][2-c].
- Required variants:
  - v1 = 4 9 2 / 3 5 7 / 8 1 6
  - v2 = 8 3 4 / 1 5 9 / 6 7 2
  - v3 = 6 1 8 / 7 5 3 / 2 9 4
  - v4 = 6 7 2 / 1 5 9 / 8 3 4
  - v5..v7 are the mirrors of v1..v3.
- Error mode: num9 is replaced by num1 of the same variant. The result has a duplicate digit and is non-magic.
- FSM states:
  - IDLE: valid=0. If start=1, clear index, latch err_mode, go to SEND.
  - SEND: valid=1 and the square is driven. If ready=1 and index==NUM_SQUARES-1, go to DONE. If ready=1 otherwise, increment index and stay in SEND. If ready=0, hold everything stable.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SEND and DONE; there is no queuing and no restart mid-run.
- err_mode changes mid-run are ignored; the latched value is used for the whole run.
- num1..num9 and index are 0 whenever valid=0.
- last = valid & (index == NUM_SQUARES-1).

## Timing
- Reset, effective at the first rising edge with reset=1:
  - state IDLE
  - valid=0, done=0, last=0, index=0, num1..num9=0
  - latched err_mode cleared
  - magic_constant stays 8'h15 at all times, including during reset.
- Reset asserted mid-run aborts immediately: the next cycle shows reset values, and no done pulse is produced.
- Start latency: start sampled high in IDLE at edge t gives valid=1 with variant 0 after edge t.
- Handshake:
  - A transfer occurs on a rising edge where valid=1 and ready=1.
  - The next square appears in the following cycle, so one square per cycle is sustained with ready held high.
  - While ready=0, valid and all data stay stable.
- Completion: the final transfer at edge t gives valid=0 and done=1 after t, then done=0 after t+1. The earliest new start is sampled at edge t+2.
- With NUM_SQUARES=1, the single square has last=1.
- All outputs except magic_constant are registered or decoded only from registered state; there is no combinational path from ready or start to any output.

## Test plan
- Reset then start=1 with err_mode=0, ready held 1:
  - valid rises one cycle after start.
  - index 0..7 on consecutive cycles, squares equal to B and v1..v7 exactly.
  - last=1 only on index 7; done pulses one cycle after it.
  - Checker reports it_is_magic=1 and unique_valid=1 on all eight squares.
- Same run with err_mode=1:
  - variant 0 presented as 2 7 6 / 9 5 1 / 4 3 2.
  - Checker reports unique_valid=0 on all eight squares.
- Backpressure, ready toggling 1,0,0,1,...:
  - Data holds during ready=0 (index 1 shown for 3 cycles).
  - No square is skipped or repeated; exactly 8 transfers and one done.
- start pulsed while in SEND and err_mode flipped mid-run:
  - Neither the sequence nor the corruption changes.
  - After done, a new start replays from index 0.
- reset asserted while index=3 is presented:
  - Next cycle valid=0, index=0, all digits 0, no done.
  - A subsequent start begins at index 0.
- NUM_SQUARES=1 and NUM_SQUARES=3:
  - Exactly 1 (resp. 3) transfers.
  - last on index 0 (resp. 2); done follows.
